irq_sequencer: RTL and testbench

IRQ_SEQUENCER -- requirements
Module: irq_sequencer

---
 rtl/irq_defs_pkg.sv | 17 +
 rtl/irq_edge_latch.sv | 30 +++
 rtl/irq_sequencer.sv | 94 +++++++++
 tb/tb_irq_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_defs_pkg.sv
// Shared definitions for the interrupt sequencer: FSM encodings, source indices
// and the cause-field width.
package irq_defs;
    localparam int NSRC_DEF = 3;
    localparam int CAUSE_W  = 2;

    localparam logic [CAUSE_W-1:0] SRC_TIMER   = 2'd0;
    localparam logic [CAUSE_W-1:0] SRC_UART_RX = 2'd1;
    localparam logic [CAUSE_W-1:0] SRC_UART_TX = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARM     = 2'b01,
        ST_FIRE    = 2'b10,
        ST_HANDLER = 2'b11
    } state_e;
endpackage

// File: rtl/irq_edge_latch.sv
// One interrupt source: rising-edge detector feeding a set/clear pending bit.
// A new edge beats a clear arriving in the same cycle.
module irq_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic src_i,
    input  logic clr_i,
    output logic pending_o
);
    logic hist_q, primed_q, pend_q, pend_d, rise;

    // The first sample after reset only loads history, so a line held high
    // across reset release is not mistaken for an edge.
    assign rise   = src_i & ~hist_q & primed_q;
    assign pend_d = rise | (pend_q & ~clr_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q   <= 1'b0;
            primed_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            hist_q   <= src_i;
            primed_q <= 1'b1;
            pend_q   <= pend_d;
        end
    end

    assign pending_o = pend_q;
endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: latches edge requests, picks the highest-priority
// enabled source and injects a one-cycle IRQ at a pipeline-safe moment.
module irq_sequencer
    import irq_defs::*;
#(
    parameter int              NSRC   = NSRC_DEF,
    parameter logic [NSRC-1:0] EN_RST = '1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NSRC-1:0]     irq_src,
    input  logic                id_valid,
    input  logic                id_stall,
    input  logic                id_pc31,
    input  logic                id_is_jump,
    input  logic                ex_branch_taken,
    input  logic                handler_exit,
    input  logic                cfg_we,
    input  logic [2*NSRC-1:0]   cfg_wdata,
    output logic                irq_out,
    output logic [CAUSE_W-1:0]  irq_cause,
    output logic [NSRC-1:0]     irq_pending,
    output logic [NSRC-1:0]     irq_enable,
    output logic                in_handler
);
    state_e               state_q, state_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d, winner;
    logic [NSRC-1:0]      enable_q, pending, clr, eligible;
    logic                 safe;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign clr[i] = ((state_q == ST_FIRE) && (cause_q == CAUSE_W'(i)))
                      | (cfg_we & cfg_wdata[NSRC+i]);
        irq_edge_latch u_latch (
            .clk      (clk),
            .reset    (reset),
            .src_i    (irq_src[i]),
            .clr_i    (clr[i]),
            .pending_o(pending[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset)       enable_q <= EN_RST;
        else if (cfg_we) enable_q <= cfg_wdata[NSRC-1:0];
    end

    assign eligible = pending & enable_q;

    always_comb begin
        winner = '0;
        for (int i = NSRC-1; i >= 0; i--)
            if (eligible[i]) winner = CAUSE_W'(i);
    end

    // Never interrupt a bubble, a stalled slot, kernel code, a jump or a flush.
    assign safe = id_valid & ~id_stall & ~id_pc31 & ~id_is_jump & ~ex_branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d = ST_ARM;
                    cause_d = winner;
                end
            end
            ST_ARM: begin
                if (!enable_q[cause_q] || !pending[cause_q]) state_d = ST_IDLE;
                else if (safe)                               state_d = ST_FIRE;
            end
            ST_FIRE:    state_d = ST_HANDLER;
            ST_HANDLER: if (handler_exit) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign irq_out     = (state_q == ST_FIRE);
    assign in_handler  = (state_q == ST_FIRE) || (state_q == ST_HANDLER);
    assign irq_cause   = cause_q;
    assign irq_pending = pending;
    assign irq_enable  = enable_q;
endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer; expected values are hand-derived per cycle.
module tb_irq_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] irq_src;
    logic       id_valid, id_stall, id_pc31, id_is_jump, ex_branch_taken;
    logic       handler_exit, cfg_we;
    logic [5:0] cfg_wdata;
    logic       irq_out, in_handler;
    logic [1:0] irq_cause;
    logic [2:0] irq_pending, irq_enable;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    irq_sequencer #(.NSRC(3), .EN_RST(3'b111)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src),
        .id_valid(id_valid), .id_stall(id_stall), .id_pc31(id_pc31),
        .id_is_jump(id_is_jump), .ex_branch_taken(ex_branch_taken),
        .handler_exit(handler_exit), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
        .irq_out(irq_out), .irq_cause(irq_cause), .irq_pending(irq_pending),
        .irq_enable(irq_enable), .in_handler(in_handler)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exit_pulse();
        handler_exit = 1'b1;
        tick();
        handler_exit = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_src = 3'b111;
        id_valid = 1'b1; id_stall = 1'b0; id_pc31 = 1'b0;
        id_is_jump = 1'b0; ex_branch_taken = 1'b0;
        handler_exit = 1'b0; cfg_we = 1'b0; cfg_wdata = '0;

        // Reset state, sources held high through release
        tick(); tick();
        chk("rst_irq_out", irq_out, 0);
        chk("rst_cause", irq_cause, 0);
        chk("rst_pending", irq_pending, 0);
        chk("rst_enable", irq_enable, 3'b111);
        chk("rst_in_handler", in_handler, 0);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("held_no_pending", irq_pending, 0);
        chk("held_no_irq", in_handler, 0);
        irq_src = 3'b000;
        tick();

        // Timer minimum latency
        irq_src = 3'b001;                       // cycle 0
        tick();                                 // cycle 1
        chk("lat_c1_pending", irq_pending, 3'b001);
        chk("lat_c1_irq", irq_out, 0);
        tick();                                 // cycle 2 (ARM)
        chk("lat_c2_irq", irq_out, 0);
        chk("lat_c2_cause", irq_cause, 0);
        tick();                                 // cycle 3 (FIRE)
        chk("lat_c3_irq", irq_out, 1);
        chk("lat_c3_inh", in_handler, 1);
        tick();                                 // cycle 4 (HANDLER)
        chk("lat_c4_irq", irq_out, 0);
        chk("lat_c4_pending", irq_pending, 0);
        chk("lat_c4_inh", in_handler, 1);
        irq_src = 3'b000;
        exit_pulse();
        chk("lat_exit_inh", in_handler, 0);

        // Simultaneous edges on 2 and 0: 0 first, then 2 back-to-back
        irq_src = 3'b101;
        tick();
        chk("pri_pending", irq_pending, 3'b101);
        tick();
        chk("pri_arm_cause", irq_cause, 0);
        tick();
        chk("pri_fire0", irq_out, 1);
        chk("pri_fire0_cause", irq_cause, 0);
        irq_src = 3'b000;
        tick();
        chk("pri_hdl_pending", irq_pending, 3'b100);
        tick();
        chk("pri_hdl_noirq", irq_out, 0);
        exit_pulse();                           // IDLE
        chk("pri_idle_inh", in_handler, 0);
        tick();                                 // ARM
        chk("pri_arm2_cause", irq_cause, 2);
        chk("pri_arm2_irq", irq_out, 0);
        tick();                                 // FIRE
        chk("pri_fire2", irq_out, 1);
        tick();
        chk("pri_fire2_once", irq_out, 0);
        chk("pri_done_pending", irq_pending, 0);
        exit_pulse();

        // ARM on cause 2 blocked by jumps, timer edge must not preempt
        id_is_jump = 1'b1;
        irq_src = 3'b100;
        tick();
        tick();                                 // ARM, cause 2
        chk("jmp_arm_cause", irq_cause, 2);
        irq_src = 3'b101;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("jmp_blocked_irq", irq_out, 0);
            chk("jmp_blocked_cause", irq_cause, 2);
        end
        chk("jmp_pending", irq_pending, 3'b101);
        id_is_jump = 1'b0;
        tick();
        chk("jmp_fire", irq_out, 1);
        chk("jmp_fire_cause", irq_cause, 2);
        irq_src = 3'b000;
        tick();
        chk("jmp_hdl_pending", irq_pending, 3'b001);
        exit_pulse();
        tick();
        tick();
        chk("jmp_fire0", irq_out, 1);
        chk("jmp_fire0_cause", irq_cause, 0);
        tick();
        exit_pulse();

        // Disable cause while in ARM: abort, pending retained
        id_valid = 1'b0;
        irq_src = 3'b010;
        tick();
        tick();                                 // ARM, cause 1
        chk("dis_arm_cause", irq_cause, 1);
        cfg_we = 1'b1; cfg_wdata = {3'b000, 3'b101};
        tick();
        cfg_we = 1'b0;
        chk("dis_enable", irq_enable, 3'b101);
        tick();                                 // back to IDLE
        id_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("dis_no_irq", irq_out, 0);
        end
        chk("dis_pending_kept", irq_pending, 3'b010);
        irq_src = 3'b000;
        cfg_we = 1'b1; cfg_wdata = {3'b010, 3'b111};
        tick();
        cfg_we = 1'b0;
        chk("dis_cleared", irq_pending, 0);
        tick();

        // Clear of bit 1 in the same cycle as a new bit-1 edge
        id_valid = 1'b0;
        irq_src = 3'b010;
        cfg_we = 1'b1; cfg_wdata = {3'b010, 3'b111};
        tick();
        cfg_we = 1'b0;
        chk("clr_edge_wins", irq_pending, 3'b010);
        tick();
        cfg_we = 1'b1; cfg_wdata = {3'b010, 3'b111};
        tick();
        cfg_we = 1'b0;
        chk("clr_plain", irq_pending, 0);
        irq_src = 3'b000;
        tick(); tick();
        chk("clr_no_irq", in_handler, 0);

        // Reset asserted in HANDLER with pending 110
        id_valid = 1'b1;
        irq_src = 3'b001;
        tick(); tick(); tick();                 // FIRE
        chk("rh_fire", irq_out, 1);
        irq_src = 3'b111;
        tick();                                 // HANDLER
        chk("rh_pending", irq_pending, 3'b110);
        chk("rh_inh", in_handler, 1);
        cfg_we = 1'b1; cfg_wdata = {3'b000, 3'b011};
        tick();
        cfg_we = 1'b0;
        chk("rh_enable_wr", irq_enable, 3'b011);
        reset = 1'b1;
        tick();
        chk("rh_pending_rst", irq_pending, 0);
        chk("rh_enable_rst", irq_enable, 3'b111);
        chk("rh_irq_rst", irq_out, 0);
        chk("rh_inh_rst", in_handler, 0);
        chk("rh_cause_rst", irq_cause, 0);
        reset = 1'b0;
        tick(); tick(); tick();
        chk("rh_held_no_pending", irq_pending, 0);
        chk("rh_held_idle", in_handler, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
